// File: rtl/etc_pkg.sv
// Shared types and constants for the ETC2 decode path.
package etc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StStep,
    StFin
  } etc_state_e;

  localparam int unsigned ETC_BLK_BYTES      = 8;
  localparam int unsigned ETC_BLK_DIM        = 4;
  localparam int unsigned ETC_TEXELS_PER_BLK = 16;

endpackage

// File: rtl/etc_blk_cnt.sv
// Raster-order 2-D block counter with running compressed-memory and framebuffer
// address accumulators; addresses wrap modulo 2^ADDR_W.
module etc_blk_cnt
  import etc_pkg::*;
#(
  parameter int unsigned       IMG_W_BLK = 8,
  parameter int unsigned       IMG_H_BLK = 8,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       BX_W      = (IMG_W_BLK > 1) ? $clog2(IMG_W_BLK) : 1,
  parameter int unsigned       BY_W      = (IMG_H_BLK > 1) ? $clog2(IMG_H_BLK) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              step,
  output logic [BX_W-1:0]   bx,
  output logic [BY_W-1:0]   by,
  output logic              last,
  output logic [ADDR_W-1:0] blk_addr,
  output logic [ADDR_W-1:0] fb_addr
);

  // One block row spans 4 texel rows of IMG_W_BLK*4 texels each.
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(IMG_W_BLK * ETC_TEXELS_PER_BLK);
  localparam logic [ADDR_W-1:0] COL_STRIDE = ADDR_W'(ETC_BLK_DIM);
  localparam logic [ADDR_W-1:0] BLK_STRIDE = ADDR_W'(ETC_BLK_BYTES);

  logic [ADDR_W-1:0] row_q;
  logic              wrap;

  assign wrap = (bx == BX_W'(IMG_W_BLK - 1));
  assign last = wrap && (by == BY_W'(IMG_H_BLK - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bx       <= '0;
      by       <= '0;
      row_q    <= '0;
      blk_addr <= BASE_ADDR;
      fb_addr  <= '0;
    end else if (clr) begin
      bx       <= '0;
      by       <= '0;
      row_q    <= '0;
      blk_addr <= BASE_ADDR;
      fb_addr  <= '0;
    end else if (step) begin
      blk_addr <= blk_addr + BLK_STRIDE;
      if (wrap) begin
        bx      <= '0;
        by      <= by + 1'b1;
        row_q   <= row_q + ROW_STRIDE;
        fb_addr <= row_q + ROW_STRIDE;
      end else begin
        bx      <= bx + 1'b1;
        fb_addr <= fb_addr + COL_STRIDE;
      end
    end
  end

endmodule

// File: rtl/etc_block_sched.sv
// ETC2 block scheduler: walks 4x4 blocks in raster order, one request per block.
// Optional watchdog enabled by defining ETC_SCHED_TIMEOUT_EN.
module etc_block_sched
  import etc_pkg::*;
#(
  parameter int unsigned       IMG_W_BLK = 8,
  parameter int unsigned       IMG_H_BLK = 8,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       TIMEOUT   = 1023
) (
  input  logic              sclk,
  input  logic              srst,
  input  logic              image_start,
  output logic              blk_req,
  input  logic              blk_ack,
  output logic [ADDR_W-1:0] blk_addr,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic              blk_done,
  output logic              busy,
  output logic              decode_finished,
  output logic              err
);

  localparam int unsigned BX_W = (IMG_W_BLK > 1) ? $clog2(IMG_W_BLK) : 1;
  localparam int unsigned BY_W = (IMG_H_BLK > 1) ? $clog2(IMG_H_BLK) : 1;

  etc_state_e      state_q, state_d;
  logic            cnt_clr, cnt_step, cnt_last;
  logic [BX_W-1:0] bx;
  logic [BY_W-1:0] by;
  logic            wdog_expired;
  logic            unused_cnt;

  assign unused_cnt = ^{bx, by};

  etc_blk_cnt #(
    .IMG_W_BLK (IMG_W_BLK),
    .IMG_H_BLK (IMG_H_BLK),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .BX_W      (BX_W),
    .BY_W      (BY_W)
  ) u_cnt (
    .clk      (sclk),
    .rst_n    (srst),
    .clr      (cnt_clr),
    .step     (cnt_step),
    .bx       (bx),
    .by       (by),
    .last     (cnt_last),
    .blk_addr (blk_addr),
    .fb_addr  (fb_addr)
  );

  always_ff @(posedge sclk or negedge srst) begin
    if (!srst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_step = 1'b0;
    unique case (state_q)
      StIdle, StFin: begin
        if (image_start) begin
          state_d = StIssue;
          cnt_clr = 1'b1;
        end
      end
      StIssue: if (blk_ack) state_d = StWait;
      StWait:  if (blk_done || wdog_expired) state_d = StStep;
      StStep: begin
        if (cnt_last) begin
          state_d = StFin;
        end else begin
          state_d  = StIssue;
          cnt_step = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign blk_req         = (state_q == StIssue);
  assign busy            = (state_q == StIssue) || (state_q == StWait) || (state_q == StStep);
  assign decode_finished = (state_q == StFin);

`ifdef ETC_SCHED_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TO_W-1:0] wdog_q;
  logic            err_q;

  // A late blk_done in the expiry cycle still wins; only a true miss flags err.
  assign wdog_expired = (state_q == StWait) && (wdog_q == TO_W'(TIMEOUT - 1));
  assign err          = err_q;

  always_ff @(posedge sclk or negedge srst) begin
    if (!srst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == StIssue && blk_ack) wdog_q <= '0;
      else if (state_q == StWait)        wdog_q <= wdog_q + 1'b1;
      if (wdog_expired && !blk_done) err_q <= 1'b1;
    end
  end
`else
  localparam int unsigned unused_timeout = TIMEOUT;

  assign wdog_expired = 1'b0;
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_etc_block_sched.sv
// Self-checking bench for etc_block_sched: directed 2x2 scenarios plus a randomized
// 5x3 walk with wrapping base address, checked against an arithmetic address model.
module tb_etc_block_sched;

  localparam int unsigned AW = 2, AH = 2;
  localparam logic [31:0] A_BASE = 32'h0000_0100;
  localparam int unsigned BW = 5, BH = 3;
  localparam logic [31:0] B_BASE = 32'hFFFF_FFF0;

  logic sclk = 1'b0;
  logic srst = 1'b0;

  logic a_start = 0, a_ack = 0, a_done = 0;
  logic a_req, a_busy, a_df, a_err;
  logic [31:0] a_blk, a_fb;

  logic b_start = 0, b_ack = 0, b_done = 0;
  logic b_req, b_busy, b_df, b_err;
  logic [31:0] b_blk, b_fb;

  int checks = 0;
  int errors = 0;

  always #5 sclk = ~sclk;

  etc_block_sched #(
    .IMG_W_BLK (AW), .IMG_H_BLK (AH), .ADDR_W (32), .BASE_ADDR (A_BASE), .TIMEOUT (16)
  ) u_dut_a (
    .sclk (sclk), .srst (srst), .image_start (a_start), .blk_req (a_req), .blk_ack (a_ack),
    .blk_addr (a_blk), .fb_addr (a_fb), .blk_done (a_done), .busy (a_busy),
    .decode_finished (a_df), .err (a_err)
  );

  etc_block_sched #(
    .IMG_W_BLK (BW), .IMG_H_BLK (BH), .ADDR_W (32), .BASE_ADDR (B_BASE), .TIMEOUT (1023)
  ) u_dut_b (
    .sclk (sclk), .srst (srst), .image_start (b_start), .blk_req (b_req), .blk_ack (b_ack),
    .blk_addr (b_blk), .fb_addr (b_fb), .blk_done (b_done), .busy (b_busy),
    .decode_finished (b_df), .err (b_err)
  );

  // Reference model: addresses straight from block index arithmetic.
  function automatic logic [31:0] exp_blk(input logic [31:0] base, input int idx);
    return base + 32'(idx) * 32'd8;
  endfunction

  function automatic logic [31:0] exp_fb(input int w, input int idx);
    int bx, by;
    bx = idx % w;
    by = idx / w;
    return 32'((by * 4) * (w * 4) + bx * 4);
  endfunction

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic start_a();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  // Serve one block on instance A, checking addresses, stall stability and D+2 timing.
  task automatic serve_a(input int idx, input int ack_dly, input int done_dly);
    int n;
    logic [31:0] eb, ef;
    eb = exp_blk(A_BASE, idx);
    ef = exp_fb(AW, idx);
    n = 0;
    while (a_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (a_req !== 1'b1) begin
      errors++;
      $display("FAIL req_wait blk %0d: got req=%b want 1", idx, a_req);
    end
    checks++;
    if (a_blk !== eb) begin
      errors++;
      $display("FAIL blk_addr blk %0d: got %h want %h", idx, a_blk, eb);
    end
    checks++;
    if (a_fb !== ef) begin
      errors++;
      $display("FAIL fb_addr blk %0d: got %h want %h", idx, a_fb, ef);
    end
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      checks++;
      if ({a_req, a_blk, a_fb} !== {1'b1, eb, ef}) begin
        errors++;
        $display("FAIL stall blk %0d cyc %0d: got req=%b blk=%h fb=%h want 1 %h %h",
                 idx, i, a_req, a_blk, a_fb, eb, ef);
      end
    end
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    checks++;
    if (a_req !== 1'b0) begin
      errors++;
      $display("FAIL req_drop blk %0d: got req=%b want 0", idx, a_req);
    end
    repeat (done_dly - 1) tick();
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    if (idx != AW * AH - 1) begin
      checks++;
      if (a_req !== 1'b0) begin
        errors++;
        $display("FAIL step_gap blk %0d: got req=%b want 0", idx, a_req);
      end
      tick();
      checks++;
      if (a_req !== 1'b1) begin
        errors++;
        $display("FAIL next_req blk %0d: got req=%b want 1", idx, a_req);
      end
    end else begin
      checks++;
      if ({a_busy, a_df} !== 2'b10) begin
        errors++;
        $display("FAIL fin_early: got busy=%b df=%b want 1 0", a_busy, a_df);
      end
      tick();
      checks++;
      if ({a_busy, a_df} !== 2'b01) begin
        errors++;
        $display("FAIL fin: got busy=%b df=%b want 0 1", a_busy, a_df);
      end
    end
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({a_req, a_busy, a_df, a_err, a_blk, a_fb} !== {4'b0000, A_BASE, 32'd0}) begin
      errors++;
      $display("FAIL reset_a: got req=%b busy=%b df=%b err=%b blk=%h fb=%h", a_req, a_busy,
               a_df, a_err, a_blk, a_fb);
    end
    checks++;
    if ({b_req, b_busy, b_df, b_err, b_blk} !== {4'b0000, B_BASE}) begin
      errors++;
      $display("FAIL reset_b: got req=%b busy=%b df=%b err=%b blk=%h", b_req, b_busy, b_df,
               b_err, b_blk);
    end
    srst = 1'b1;
    tick();
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    tick();
    checks++;
    if ({a_req, a_busy, a_df} !== 3'b000) begin
      errors++;
      $display("FAIL idle_done: got req=%b busy=%b df=%b want 000", a_req, a_busy, a_df);
    end
  endtask

  task automatic test_basic();
    start_a();
    checks++;
    if ({a_busy, a_req, a_blk, a_fb} !== {2'b11, A_BASE, 32'd0}) begin
      errors++;
      $display("FAIL start: got busy=%b req=%b blk=%h fb=%h", a_busy, a_req, a_blk, a_fb);
    end
    for (int i = 0; i < AW * AH; i++) serve_a(i, 0, 5);
  endtask

  task automatic test_stall_restart();
    start_a();
    checks++;
    if ({a_df, a_blk} !== {1'b0, A_BASE}) begin
      errors++;
      $display("FAIL restart: got df=%b blk=%h want 0 %h", a_df, a_blk, A_BASE);
    end
    for (int i = 0; i < AW * AH; i++) serve_a(i, 10, 3);
  endtask

  task automatic test_ignore();
    start_a();
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    checks++;
    if ({a_req, a_busy, a_blk} !== {2'b01, exp_blk(A_BASE, 0)}) begin
      errors++;
      $display("FAIL start_in_wait: got req=%b busy=%b blk=%h", a_req, a_busy, a_blk);
    end
    tick();
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    tick();
    checks++;
    if ({a_req, a_blk} !== {1'b1, exp_blk(A_BASE, 1)}) begin
      errors++;
      $display("FAIL after_ignore: got req=%b blk=%h want 1 %h", a_req, a_blk,
               exp_blk(A_BASE, 1));
    end
    a_ack  = 1'b1;
    a_done = 1'b1;
    tick();
    a_ack  = 1'b0;
    a_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({a_req, a_busy, a_blk} !== {2'b01, exp_blk(A_BASE, 1)}) begin
        errors++;
        $display("FAIL coincident_done cyc %0d: got req=%b busy=%b blk=%h", i, a_req, a_busy,
                 a_blk);
      end
    end
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    tick();
    serve_a(2, 0, 1);
    serve_a(3, 1, 2);
  endtask

  task automatic test_reset_mid();
    start_a();
    serve_a(0, 0, 2);
    serve_a(1, 1, 2);
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    tick();
    #2 srst = 1'b0;
    #1;
    checks++;
    if ({a_req, a_busy, a_df, a_err, a_blk, a_fb} !== {4'b0000, A_BASE, 32'd0}) begin
      errors++;
      $display("FAIL async_reset: got req=%b busy=%b df=%b err=%b blk=%h fb=%h", a_req, a_busy,
               a_df, a_err, a_blk, a_fb);
    end
    tick();
    srst = 1'b1;
    tick();
    start_a();
    for (int i = 0; i < AW * AH; i++) serve_a(i, 0, 3);
  endtask

  task automatic test_random();
    int n, xfers;
    logic [31:0] eb, ef;
    for (int img = 0; img < 2; img++) begin
      xfers   = 0;
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      for (int idx = 0; idx < int'(BW * BH); idx++) begin
        eb = exp_blk(B_BASE, idx);
        ef = exp_fb(BW, idx);
        n  = 0;
        while (b_req !== 1'b1 && n < 20) begin
          tick();
          n++;
        end
        checks++;
        if ({b_req, b_blk, b_fb} !== {1'b1, eb, ef}) begin
          errors++;
          $display("FAIL rnd img %0d blk %0d: got req=%b blk=%h fb=%h want 1 %h %h", img, idx,
                   b_req, b_blk, b_fb, eb, ef);
        end
        repeat ($urandom_range(0, 4)) begin
          b_done = 1'($urandom_range(0, 1));
          tick();
          checks++;
          if ({b_req, b_blk, b_fb} !== {1'b1, eb, ef}) begin
            errors++;
            $display("FAIL rnd_stall blk %0d: got req=%b blk=%h fb=%h", idx, b_req, b_blk, b_fb);
          end
        end
        b_ack  = 1'b1;
        b_done = 1'($urandom_range(0, 1));
        tick();
        xfers++;
        b_ack   = 1'b0;
        b_done  = 1'b0;
        b_start = 1'($urandom_range(0, 1));
        repeat ($urandom_range(0, 5)) begin
          tick();
          b_start = 1'b0;
        end
        b_start = 1'b0;
        b_done  = 1'b1;
        tick();
        b_done = 1'b0;
        tick();
      end
      tick();
      checks++;
      if ({b_busy, b_df, b_err} !== 3'b010 || xfers != int'(BW * BH)) begin
        errors++;
        $display("FAIL rnd_fin img %0d: got busy=%b df=%b err=%b xfers=%0d want 0 1 0 %0d",
                 img, b_busy, b_df, b_err, xfers, BW * BH);
      end
    end
  endtask

`ifdef ETC_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    start_a();
    serve_a(0, 0, 2);
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    repeat (15) tick();
    checks++;
    if ({a_err, a_req} !== 2'b00) begin
      errors++;
      $display("FAIL wdog_early: got err=%b req=%b want 0 0", a_err, a_req);
    end
    tick();
    checks++;
    if ({a_err, a_req} !== 2'b10) begin
      errors++;
      $display("FAIL wdog_fire: got err=%b req=%b want 1 0", a_err, a_req);
    end
    tick();
    checks++;
    if ({a_req, a_blk} !== {1'b1, exp_blk(A_BASE, 2)}) begin
      errors++;
      $display("FAIL wdog_skip: got req=%b blk=%h want 1 %h", a_req, a_blk, exp_blk(A_BASE, 2));
    end
    serve_a(2, 0, 2);
    serve_a(3, 0, 2);
    checks++;
    if ({a_err, a_df} !== 2'b11) begin
      errors++;
      $display("FAIL wdog_sticky: got err=%b df=%b want 1 1", a_err, a_df);
    end
    srst = 1'b0;
    tick();
    srst = 1'b1;
    checks++;
    if (a_err !== 1'b0) begin
      errors++;
      $display("FAIL wdog_clear: got err=%b want 0", a_err);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall_restart();
    test_ignore();
    test_reset_mid();
    test_random();
`ifdef ETC_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
